// File: rtl/squash_arbiter_pkg.sv
// Shared squash types and the ROB age comparison used by the ROB, the LSQ
// and the squash arbiter.
package squash_arbiter_pkg;

  localparam int ROB_SIZE  = 64;
  localparam int ROB_IDX_W = $clog2(ROB_SIZE);
  localparam int XLEN      = 64;
  // Folded-pc width used by the memory-dependence predictor.
  localparam int FOLDPC_W  = 10;

  // ROB index with a wrap flag that toggles each time idx wraps around.
  typedef struct packed {
    logic                 flag;
    logic [ROB_IDX_W-1:0] idx;
  } robIdx_t;

  localparam int ROB_W = $bits(robIdx_t);

  typedef struct packed {
    logic                due_to_branch;
    logic                due_to_violation;
    logic                branch_taken;
    logic [XLEN-1:0]     arch_pc;
    logic [FOLDPC_W-1:0] st_foldpc;
    logic [FOLDPC_W-1:0] ld_foldpc;
  } squashInfo_t;

  // a is older than b: same lap -> smaller idx; different lap -> larger idx.
  function automatic logic rob_older(robIdx_t a, robIdx_t b);
    return (a.flag == b.flag) ? (a.idx < b.idx) : (a.idx > b.idx);
  endfunction

endpackage

// File: rtl/rob_age_select.sv
// Tournament tree over N robIdx-tagged requests: returns the oldest valid
// entry. On equal age the lower index wins (the left subtree is preferred
// unless the right one is strictly older).
module rob_age_select
  import squash_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = ROB_W,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   vld,
  input  logic [N*W-1:0] rob_idx,
  output logic           win_vld,
  output logic [IW-1:0]  win_idx,
  output logic [W-1:0]   win_rob
);

  localparam int LVLS  = $clog2(N);
  localparam int LEAFS = 1 << LVLS;
  localparam int NODES = 2 * LEAFS - 1;

  // Pad the request set to a power of two; padded leaves are never valid.
  logic [LEAFS-1:0]   vld_pad;
  logic [LEAFS*W-1:0] rob_pad;

  assign vld_pad = LEAFS'(vld);
  assign rob_pad = (LEAFS*W)'(rob_idx);

  // Heap-ordered tree: node k has children 2k+1 (lower indices) and 2k+2.
  logic          node_vld [NODES];
  logic [IW-1:0] node_idx [NODES];
  logic [W-1:0]  node_rob [NODES];

  // Fill the leaves, then reduce pairwise from the bottom level to the root.
  always_comb begin
    for (int k = 0; k < NODES; k++) begin
      node_vld[k] = 1'b0;
      node_idx[k] = '0;
      node_rob[k] = '0;
    end
    for (int k = 0; k < LEAFS; k++) begin
      node_vld[LEAFS-1+k] = vld_pad[k];
      node_idx[LEAFS-1+k] = IW'(k);
      node_rob[LEAFS-1+k] = rob_pad[k*W +: W];
    end
    for (int k = LEAFS - 2; k >= 0; k--) begin
      if (node_vld[2*k+2] &&
          (!node_vld[2*k+1] || rob_older(node_rob[2*k+2], node_rob[2*k+1]))) begin
        node_vld[k] = 1'b1;
        node_idx[k] = node_idx[2*k+2];
        node_rob[k] = node_rob[2*k+2];
      end else begin
        node_vld[k] = node_vld[2*k+1];
        node_idx[k] = node_idx[2*k+1];
        node_rob[k] = node_rob[2*k+1];
      end
    end
  end

  assign win_vld = node_vld[0];
  assign win_idx = node_idx[0];
  assign win_rob = node_rob[0];

endmodule

// File: rtl/squash_arbiter.sv
// Squash arbiter: gathers branch mispredicts and load-order violations,
// keeps the single oldest pending squash until the ROB consumes it.
module squash_arbiter
  import squash_arbiter_pkg::*;
#(
  parameter int BRU_WB = 2,
  parameter int LDU_WB = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BRU_WB-1:0]        i_bwb_vld,
  input  logic [BRU_WB*ROB_W-1:0]  i_bwb_rob_idx,
  input  logic [BRU_WB-1:0]        i_bwb_mispred,
  input  logic [BRU_WB-1:0]        i_bwb_taken,
  input  logic [BRU_WB*XLEN-1:0]   i_bwb_npc,
  input  logic [LDU_WB-1:0]        i_viol_vld,
  input  logic [LDU_WB*ROB_W-1:0]  i_viol_rob_idx,
  input  logic [LDU_WB*XLEN-1:0]   i_viol_pc,
  input  logic [LDU_WB*FOLDPC_W-1:0] i_viol_ld_foldpc,
  input  logic [LDU_WB*FOLDPC_W-1:0] i_viol_st_foldpc,
  input  logic                     i_consume,
  input  logic                     i_flush,
  output logic                     o_pend_vld,
  output robIdx_t                  o_pend_rob_idx,
  output squashInfo_t              o_squash
);

  localparam int N  = BRU_WB + LDU_WB;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  // Branch channels occupy the low indices so they win equal-age ties.
  logic [N-1:0]       cand_vld;
  logic [N*ROB_W-1:0] cand_rob;
  squashInfo_t        cand_info [N];

  genvar gi;
  generate
    for (gi = 0; gi < BRU_WB; gi++) begin : g_bru
      assign cand_vld[gi]               = i_bwb_vld[gi] & i_bwb_mispred[gi];
      assign cand_rob[gi*ROB_W +: ROB_W] = i_bwb_rob_idx[gi*ROB_W +: ROB_W];
      assign cand_info[gi] = '{due_to_branch:    1'b1,
                               due_to_violation: 1'b0,
                               branch_taken:     i_bwb_taken[gi],
                               arch_pc:          i_bwb_npc[gi*XLEN +: XLEN],
                               st_foldpc:        '0,
                               ld_foldpc:        '0};
    end
    for (gi = 0; gi < LDU_WB; gi++) begin : g_ldu
      assign cand_vld[BRU_WB+gi]                  = i_viol_vld[gi];
      assign cand_rob[(BRU_WB+gi)*ROB_W +: ROB_W] = i_viol_rob_idx[gi*ROB_W +: ROB_W];
      assign cand_info[BRU_WB+gi] = '{due_to_branch:    1'b0,
                                      due_to_violation: 1'b1,
                                      branch_taken:     1'b0,
                                      arch_pc:          i_viol_pc[gi*XLEN +: XLEN],
                                      st_foldpc:        i_viol_st_foldpc[gi*FOLDPC_W +: FOLDPC_W],
                                      ld_foldpc:        i_viol_ld_foldpc[gi*FOLDPC_W +: FOLDPC_W]};
    end
  endgenerate

  logic             win_vld;
  logic [IW-1:0]    win_idx;
  logic [ROB_W-1:0] win_rob;
  robIdx_t          sel_rob;
  squashInfo_t      sel_info;

  rob_age_select #(
    .N (N),
    .W (ROB_W)
  ) u_age_select (
    .vld     (cand_vld),
    .rob_idx (cand_rob),
    .win_vld (win_vld),
    .win_idx (win_idx),
    .win_rob (win_rob)
  );

  assign sel_rob  = win_rob;
  assign sel_info = cand_info[win_idx];

  logic        pend_vld_next;
  robIdx_t     pend_rob_next;
  squashInfo_t squash_next;

  // Decide whether the held candidate is cleared, reloaded, replaced or kept.
  always_comb begin
    pend_vld_next = o_pend_vld;
    pend_rob_next = o_pend_rob_idx;
    squash_next   = o_squash;
    if (i_flush) begin
      pend_vld_next = 1'b0;
      pend_rob_next = '0;
      squash_next   = '0;
    end else if (!o_pend_vld || i_consume) begin
      // Slot is free (or being freed): take this cycle's winner, if any.
      pend_vld_next = win_vld;
      pend_rob_next = win_vld ? sel_rob  : '0;
      squash_next   = win_vld ? sel_info : '0;
    end else if (win_vld && rob_older(sel_rob, o_pend_rob_idx)) begin
      // Strictly older only: an equal robIdx never displaces the holder.
      pend_vld_next = 1'b1;
      pend_rob_next = sel_rob;
      squash_next   = sel_info;
    end
  end

  // Pending-candidate register; outputs come straight from these flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_pend_vld     <= 1'b0;
      o_pend_rob_idx <= '0;
      o_squash       <= '0;
    end else begin
      o_pend_vld     <= pend_vld_next;
      o_pend_rob_idx <= pend_rob_next;
      o_squash       <= squash_next;
    end
  end

  // The ROB may only consume a squash that is actually being held.
  consume_needs_pending: assert property (
    @(posedge clk) disable iff (!rst) i_consume |-> o_pend_vld
  );

endmodule
